multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified memory port, one register file.
- Drives the instruction register, PC update, memory strobes, mux selects and ALU op class per cycle.
- Sits beside the datapath in place of a single-cycle decoder, taking opcode/funct3 from the IR.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- STATE_W, 4, state register width; all state encodings below fit in it.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- opcode  in  7  IR[6:0]; stable from DECODE until the next FETCH completes
- funct3  in  3  IR[14:12]
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memWrite  out  1  write strobe for mem_req
- adrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- irWrite  out  1  latch IR and OldPC
- pcWrite  out  1  PC <= Result
- regWrite  out  1  rd <= Result
- resultSrc  out  2  Result select: 00=ALUOut, 01=Data, 10=ALUResult
- aluSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero
- aluSrcB  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4
- ALUOp  out  2  ALU op class: 00=add, 01=branch compare, 10=funct decode
- ImmSrc  out  3  immediate type: I=000, S=001, B=010, U=011, J=100
- branch  out  4  {in BRANCH state, funct3}
- jalr  out  1  datapath clears bit0 of the PC target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_instr  out  1  see Optional Feature

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
  - rst forces state to FETCH.
  - While rst=1, pcWrite, irWrite, regWrite, memWrite, mem_req and instr_done are all 0.
  - Reset mid-access abandons that access; no write strobe is emitted.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, UPPER=12, LINK=13, TRAP=14.
- ImmSrc: decoded combinationally from opcode every cycle.
  - I-type: load, I-arith, JALR. S-type: store. B-type: branch. U-type: LUI, AUIPC. J-type: JAL.
  - Unknown opcode gives 000.
- Defaults: every output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: mem_req=1, adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10.
    - irWrite=pcWrite=mem_ready.
    - Go to DECODE when mem_ready=1, else hold with no side effects.
  - DECODE: aluSrcA=01, aluSrcB=01, ALUOp=00, so ALUOut = OldPC+imm.
    - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111/0010111 -> UPPER.
    - Any other opcode -> FETCH with instr_done=1.
  - MEMADR: aluSrcA=10, aluSrcB=01, ALUOp=00. Load goes to MEMREAD, store to MEMWRITE.
  - MEMREAD: mem_req=1, adrSrc=1. Go to MEMWB on mem_ready, else hold.
  - MEMWB: resultSrc=01, regWrite=1, instr_done=1. Go to FETCH.
  - MEMWRITE: mem_req=1, adrSrc=1, memWrite=1.
    - On mem_ready: instr_done=1, go to FETCH. Otherwise hold with strobes steady.
  - EXECR: aluSrcA=10, aluSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECI: aluSrcA=10, aluSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: resultSrc=00, regWrite=1, instr_done=1. Go to FETCH.
  - BRANCH: aluSrcA=10, aluSrcB=00, ALUOp=01, resultSrc=00, branch[3]=1.
    - The datapath qualifies pcWrite with the comparison. instr_done=1. Go to FETCH.
  - JAL: resultSrc=00, pcWrite=1. Go to LINK.
  - JALR: aluSrcA=10, aluSrcB=01, resultSrc=10, pcWrite=1, jalr=1. Go to LINK.
  - LINK: aluSrcA=01, aluSrcB=10, resultSrc=10, regWrite=1, instr_done=1. Go to FETCH.
  - UPPER: aluSrcB=01, ALUOp=00. aluSrcA=11 for LUI, 01 for AUIPC. Go to ALUWB.
- Cycle counts with mem_ready tied to 1: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL/JALR 4.
- Each memory wait cycle adds 1.
- Unreachable state encodings (including 14 without the feature and 15) go to FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP.
  - TRAP asserts illegal_instr=1 with all strobes 0, and holds until rst.
- Undefined: TRAP state is not built, illegal_instr is tied to 0, and unknown opcodes retire as NOP (DECODE -> FETCH).

Test Plan:
- add x3,x1,x2 (0110011), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB. regWrite=1 only in ALUWB. instr_done at cycle 4.
- lw (0000011) with mem_ready low 3 cycles in MEMREAD -> state holds at 3. MEMWB reached 1 cycle after mem_ready. regWrite=1, resultSrc=01.
- beq (1100011, funct3=000) -> branch=4'b1000 in BRANCH, ALUOp=01, aluSrcA=10, aluSrcB=00. Total 3 cycles.
- jalr (1100111) -> JALR shows pcWrite=1, jalr=1. LINK shows regWrite=1, aluSrcA=01, aluSrcB=10.
- rst pulsed during MEMWRITE with mem_ready=0 -> memWrite drops immediately, without waiting for a clock edge. State is FETCH after release.
- opcode 0000000 -> FETCH after DECODE without ILLEGAL_TRAP_EN. With it, TRAP and illegal_instr=1 persist until rst.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-resource multicycle RV32I datapath.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park in TRAP instead of retiring as NOP.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memWrite,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic [3:0] branch,
    output logic       jalr,
    output logic       instr_done,
    output logic       illegal_instr
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
        S_UPPER = 4'd12, S_LINK = 4'd13, S_TRAP = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [3:0] branch;
        logic       jalr;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Moore outputs of a state; opcode/funct3 are already stable whenever they matter.
    function automatic ctrl_t state_ctrl(input state_t st, input logic [6:0] op,
                                         input logic [2:0] f3);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.instr_done = 1'b1; end
            S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            S_ALUWB:    begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a  = 2'b10;
                c.alu_op     = 2'b01;
                c.branch     = {1'b1, f3};
                c.instr_done = 1'b1;
            end
            S_JAL:      c.pc_write = 1'b1;
            S_JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
                c.jalr       = 1'b1;
            end
            S_LINK: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_UPPER: begin
                c.alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
                c.alu_src_b = 2'b01;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     c.illegal = 1'b1;
`endif
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    state_t state_q, state_d;
    ctrl_t  out_q, out_d;
    logic   fetch_go_s, store_done_s, decode_nop_s, strobe_en_s;

    // Next-state logic and the registered outputs of that next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_UPPER: state_d = S_ALUWB;
            S_JAL, S_JALR: state_d = S_LINK;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
        out_d = state_ctrl(state_d, opcode, funct3);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            out_q   <= state_ctrl(S_FETCH, 7'd0, 3'd0);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Immediate type follows the IR opcode directly.
    always_comb begin
        case (opcode)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BR:                  ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b011;
            OP_JAL:                 ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    // Handshake-qualified strobes; rst kills every strobe without waiting for a clock.
    assign strobe_en_s  = ~rst;
    assign fetch_go_s   = (state_q == S_FETCH) & mem_ready;
    assign store_done_s = (state_q == S_MEMWRITE) & mem_ready;
`ifdef ILLEGAL_TRAP_EN
    assign decode_nop_s = 1'b0;
`else
    assign decode_nop_s = (state_q == S_DECODE) & ~op_known(opcode);
`endif

    assign mem_req       = out_q.mem_req & strobe_en_s;
    assign memWrite      = out_q.mem_write & strobe_en_s;
    assign irWrite       = fetch_go_s & strobe_en_s;
    assign pcWrite       = (out_q.pc_write | fetch_go_s) & strobe_en_s;
    assign regWrite      = out_q.reg_write & strobe_en_s;
    assign instr_done    = (out_q.instr_done | store_done_s | decode_nop_s) & strobe_en_s;
    assign adrSrc        = out_q.adr_src;
    assign resultSrc     = out_q.result_src;
    assign aluSrcA       = out_q.alu_src_a;
    assign aluSrcB       = out_q.alu_src_b;
    assign ALUOp         = out_q.alu_op;
    assign branch        = out_q.branch;
    assign jalr          = out_q.jalr;
    assign illegal_instr = out_q.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       mem_req, memWrite, adrSrc, irWrite, pcWrite, regWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] branch;
    logic       jalr, instr_done, illegal_instr;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
        .mem_req(mem_req), .memWrite(memWrite), .adrSrc(adrSrc), .irWrite(irWrite),
        .pcWrite(pcWrite), .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .branch(branch), .jalr(jalr),
        .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    logic [23:0] obs_s;
    assign obs_s = {mem_req, memWrite, adrSrc, irWrite, pcWrite, regWrite, resultSrc,
                    aluSrcA, aluSrcB, ALUOp, ImmSrc, branch, jalr, instr_done, illegal_instr};

    typedef enum int {
        B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_MEMWRITE, B_EXECR, B_EXECI,
        B_ALUWB, B_BRANCH, B_JAL, B_JALR, B_UPPER, B_LINK, B_TRAP
    } bst_t;

    typedef struct {
        bst_t        st;
        logic        mr;
        logic [23:0] exp;
    } phase_t;

    phase_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
    endtask

    function automatic logic [2:0] imm_exp(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011:                         return 3'b001;
            7'b1100011:                         return 3'b010;
            7'b0110111, 7'b0010111:             return 3'b011;
            7'b1101111:                         return 3'b100;
            default:                            return 3'b000;
        endcase
    endfunction

    function automatic logic known(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic trap_build();
`ifdef ILLEGAL_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [23:0] exp_out(input bst_t st, input logic mr,
                                            input logic [6:0] op, input logic [2:0] f3);
        logic mreq = 1'b0, mw = 1'b0, adr = 1'b0, irw = 1'b0, pcw = 1'b0, rw = 1'b0;
        logic jr = 1'b0, dn = 1'b0, ill = 1'b0;
        logic [1:0] rs = 2'b00, a = 2'b00, b = 2'b00, ao = 2'b00;
        logic [3:0] br = 4'b0000;
        case (st)
            B_FETCH:    begin mreq = 1'b1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            B_DECODE:   begin a = 2'b01; b = 2'b01; dn = !known(op) && !trap_build(); end
            B_MEMADR:   begin a = 2'b10; b = 2'b01; end
            B_MEMREAD:  begin mreq = 1'b1; adr = 1'b1; end
            B_MEMWB:    begin rs = 2'b01; rw = 1'b1; dn = 1'b1; end
            B_MEMWRITE: begin mreq = 1'b1; adr = 1'b1; mw = 1'b1; dn = mr; end
            B_EXECR:    begin a = 2'b10; ao = 2'b10; end
            B_EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
            B_ALUWB:    begin rw = 1'b1; dn = 1'b1; end
            B_BRANCH:   begin a = 2'b10; ao = 2'b01; br = {1'b1, f3}; dn = 1'b1; end
            B_JAL:      pcw = 1'b1;
            B_JALR:     begin a = 2'b10; b = 2'b01; rs = 2'b10; pcw = 1'b1; jr = 1'b1; end
            B_LINK:     begin a = 2'b01; b = 2'b10; rs = 2'b10; rw = 1'b1; dn = 1'b1; end
            B_UPPER:    begin a = (op == 7'b0110111) ? 2'b11 : 2'b01; b = 2'b01; end
            B_TRAP:     ill = 1'b1;
            default:    ill = 1'b0;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, rs, a, b, ao, imm_exp(op), br, jr, dn, ill};
    endfunction

    function automatic logic [23:0] rst_vec(input logic [6:0] op);
        logic [23:0] v;
        v = exp_out(B_FETCH, 1'b0, op, 3'd0);
        v[23] = 1'b0;
        return v;
    endfunction

    task automatic push(input bst_t st, input logic mr, input logic [6:0] op, input logic [2:0] f3);
        phase_t p;
        p.st  = st;
        p.mr  = mr;
        p.exp = exp_out(st, mr, op, f3);
        q.push_back(p);
    endtask

    // Builds the expected cycle sequence for one instruction, then drives/compares it.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int wf, input int wm, input int keep);
        phase_t p;
        q.delete();
        for (int i = 0; i < wf; i++) push(B_FETCH, 1'b0, op, f3);
        push(B_FETCH, 1'b1, op, f3);
        push(B_DECODE, 1'($urandom_range(0, 1)), op, f3);
        case (op)
            7'b0000011: begin
                push(B_MEMADR, 1'b1, op, f3);
                for (int i = 0; i < wm; i++) push(B_MEMREAD, 1'b0, op, f3);
                push(B_MEMREAD, 1'b1, op, f3);
                push(B_MEMWB, 1'b0, op, f3);
            end
            7'b0100011: begin
                push(B_MEMADR, 1'b1, op, f3);
                for (int i = 0; i < wm; i++) push(B_MEMWRITE, 1'b0, op, f3);
                push(B_MEMWRITE, 1'b1, op, f3);
            end
            7'b0110011: begin push(B_EXECR, 1'b1, op, f3); push(B_ALUWB, 1'b1, op, f3); end
            7'b0010011: begin push(B_EXECI, 1'b0, op, f3); push(B_ALUWB, 1'b1, op, f3); end
            7'b1100011: push(B_BRANCH, 1'b1, op, f3);
            7'b1101111: begin push(B_JAL, 1'b1, op, f3); push(B_LINK, 1'b0, op, f3); end
            7'b1100111: begin push(B_JALR, 1'b0, op, f3); push(B_LINK, 1'b1, op, f3); end
            7'b0110111, 7'b0010111: begin
                push(B_UPPER, 1'b1, op, f3);
                push(B_ALUWB, 1'b0, op, f3);
            end
            default: begin
                if (trap_build())
                    for (int i = 0; i < 4; i++) push(B_TRAP, 1'($urandom_range(0, 1)), op, f3);
            end
        endcase
        while (q.size() > keep) void'(q.pop_back());
        opcode = op;
        funct3 = f3;
        while (q.size() > 0) begin
            p = q.pop_front();
            mem_ready = p.mr;
            @(negedge clk);
            check_eq(p.st.name(), obs_s, p.exp);
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        funct3 = 3'd0;
        #3;
        check_eq("reset_outputs", obs_s, rst_vec(opcode));
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_instr(7'b0110011, 3'd0, 0, 0, 99);   // add
        run_instr(7'b0000011, 3'd2, 0, 3, 99);   // lw, 3 wait cycles
        run_instr(7'b0100011, 3'd2, 1, 0, 99);   // sw
        run_instr(7'b0010011, 3'd0, 2, 0, 99);   // addi after fetch waits
        run_instr(7'b1100011, 3'd0, 0, 0, 99);   // beq
        run_instr(7'b1100011, 3'd1, 0, 0, 99);   // bne
        run_instr(7'b1101111, 3'd0, 0, 0, 99);   // jal
        run_instr(7'b1100111, 3'd0, 0, 0, 99);   // jalr
        run_instr(7'b0110111, 3'd0, 0, 0, 99);   // lui
        run_instr(7'b0010111, 3'd0, 0, 0, 99);   // auipc
        for (int k = 0; k < 10; k++)
            run_instr(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      $urandom_range(0, 2), $urandom_range(0, 2), 99);

        // Reset in the middle of a stalled store.
        run_instr(7'b0100011, 3'd2, 0, 5, 5);
        #2;
        check_eq("mw_before_rst", {23'd0, memWrite}, 24'd1);
        rst = 1'b1;
        #1;
        check_eq("mw_async_drop", {22'd0, memWrite, mem_req}, 24'd0);
        @(negedge clk);
        check_eq("in_rst_vec", obs_s, rst_vec(opcode));
        rst = 1'b0;
        @(negedge clk);
        check_eq("fetch_after_rst", obs_s, exp_out(B_FETCH, 1'b0, opcode, funct3));
        @(posedge clk);
        #1;
        run_instr(7'b0110011, 3'd0, 0, 0, 99);

        // Unknown opcode: NOP retire, or TRAP until reset.
        run_instr(7'b0000000, 3'd0, 0, 0, 99);
        if (!trap_build()) run_instr(7'b0110011, 3'd0, 0, 0, 99);
        rst = 1'b1;
        #1;
        check_eq("final_rst", obs_s, rst_vec(opcode));
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("final_fetch", obs_s, exp_out(B_FETCH, 1'b0, opcode, funct3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
